instr_fetch_unit: RTL

- Fetch stage directly upstream of the opcode-decoding control unit.
- Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words in a small prefetch FIFO and presents them downstream with a valid/ready handshake.
- Exports the full instruction, its PC, and the opcode field (instr[31:26]) that drives the control unit's instr_op input.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid channel, redirect input and the
// valid/ready instruction output toward decode. master = fetch unit side.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [31:0]       imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              if_valid;
   logic              if_ready;
   logic [31:0]       if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic [5:0]        if_op;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_op,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_op,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory request issue, prefetch FIFO and redirect/drain handling.
// Define IFU_BYPASS_EN to let a response reach if_* combinationally when the FIFO is empty.
module instr_fetch_unit #(
   parameter int unsigned        ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter int unsigned        MAX_OUT    = 2
) (
   input logic                clk,
   input logic                rst_n,
   instr_fetch_unit_if.master bus
);
   localparam int unsigned FPW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = FPW + 1;
   localparam int unsigned OW  = $clog2(MAX_OUT + 1);
   localparam int unsigned QPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFetch = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [OW-1:0]     out_q, out_d;
   logic [OW-1:0]     disc_q, disc_d;
   logic [FPW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [QPW-1:0]    pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;

   logic [31:0]       fifo_instr_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];
   logic [ADDR_W-1:0] pcq_q        [MAX_OUT];

   logic              req, grant, rv_ok, push, pop, bypass, fifo_empty, redir;
   logic [31:0]       head_instr;
   logic [ADDR_W-1:0] head_pc;

   always_comb begin
      redir      = bus.redirect_valid;
      fifo_empty = (count_q == '0);
      req        = (state_q == StFetch) &&
                   ((32'(count_q) + 32'(out_q)) < FIFO_DEPTH) &&
                   (32'(out_q) < MAX_OUT);
      grant      = req && bus.imem_gnt;
      // Responses with nothing outstanding are protocol errors and are dropped.
      rv_ok      = bus.imem_rvalid && (out_q != '0);
`ifdef IFU_BYPASS_EN
      bypass     = fifo_empty && (disc_q == '0) && !redir && rv_ok;
`else
      bypass     = 1'b0;
`endif
      head_instr = bypass ? bus.imem_rdata : fifo_instr_q[rd_ptr_q];
      head_pc    = bypass ? pcq_q[pcq_rd_q] : fifo_pc_q[rd_ptr_q];
      pop        = !fifo_empty && bus.if_ready;
      push       = rv_ok && (disc_q == '0) && !redir && !(bypass && bus.if_ready);

      bus.imem_req  = req;
      bus.imem_addr = pc_q;
      bus.if_valid  = !fifo_empty || bypass;
      bus.if_instr  = bus.if_valid ? head_instr : '0;
      bus.if_pc     = bus.if_valid ? head_pc : '0;
      bus.if_op     = bus.if_valid ? head_instr[31:26] : '0;
   end

   always_comb begin
      state_d  = state_q;
      disc_d   = disc_q;
      pc_d     = grant ? pc_q + ADDR_W'(4) : pc_q;
      out_d    = out_q + OW'(grant) - OW'(rv_ok);
      rd_ptr_d = pop  ? rd_ptr_q + FPW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + FPW'(1) : wr_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      pcq_wr_d = pcq_wr_q;
      pcq_rd_d = pcq_rd_q;
      if (grant) pcq_wr_d = (pcq_wr_q == QPW'(MAX_OUT - 1)) ? '0 : pcq_wr_q + QPW'(1);
      // The PC queue pops on every accepted response, discarded or not, to stay aligned.
      if (rv_ok) pcq_rd_d = (pcq_rd_q == QPW'(MAX_OUT - 1)) ? '0 : pcq_rd_q + QPW'(1);

      unique case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: state_d = StFetch;
         StDrain: begin
            if (rv_ok && (disc_q != '0)) begin
               disc_d = disc_q - OW'(1);
               if (disc_q == OW'(1)) state_d = StFetch;
            end
         end
         default: state_d = StIdle;
      endcase

      if (redir) begin
         pc_d     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         disc_d   = out_d;
         state_d  = (out_d != '0) ? StDrain : StFetch;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         pc_q     <= {RESET_PC[ADDR_W-1:2], 2'b00};
         out_q    <= '0;
         disc_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         pcq_rd_q <= '0;
         pcq_wr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         out_q    <= out_d;
         disc_q   <= disc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         pcq_rd_q <= pcq_rd_d;
         pcq_wr_q <= pcq_wr_d;
      end
   end

   // Data storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
         fifo_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
      end
      if (grant) pcq_q[pcq_wr_q] <= pc_q;
   end
endmodule
